// File: rtl/systolic_seq_ctrl_if.sv
// Control/data bundle between the systolic sequencer and its instruction,
// operand, PE-array and output memories.
interface systolic_seq_ctrl_if #(
    parameter int N        = 4,
    parameter int DW       = 16,
    parameter int CW       = 8,
    parameter int MAX_INST = 8,
    parameter int IW       = 5,
    parameter int OW       = 7
);
    localparam int IAW = $clog2(MAX_INST);
    localparam int SW  = $clog2(N * N);

    logic              ap_start;
    logic              ap_done;
    logic              ap_idle;
    logic [IAW-1:0]    inst_addr;
    logic [IW-1:0]     inst_data;
    logic [IW-1:0]     cur_inst;
    logic [CW-1:0]     mem_col;
    logic              mem_rd;
    logic              pe_en;
    logic              acc_clr;
    logic [SW-1:0]     res_sel;
    logic [2*DW-1:0]   res_data;
    logic              out_wr;
    logic [OW-1:0]     out_addr;
    logic [2*DW-1:0]   out_data;
    logic              err;

    modport master (
        input  ap_start, inst_data, res_data,
        output ap_done, ap_idle, inst_addr, cur_inst, mem_col, mem_rd,
               pe_en, acc_clr, res_sel, out_wr, out_addr, out_data, err
    );

    modport slave (
        output ap_start, inst_data, res_data,
        input  ap_done, ap_idle, inst_addr, cur_inst, mem_col, mem_rd,
               pe_en, acc_clr, res_sel, out_wr, out_addr, out_data, err
    );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Instruction sequencer for an N x N systolic array: fetches K, streams the
// skewed A/B columns, drains the N*N results to output memory, then clears.
module systolic_seq_ctrl #(
    parameter int N        = 4,
    parameter int DW       = 16,
    parameter int CW       = 8,
    parameter int MAX_INST = 8,
    parameter int IW       = 5,
    parameter int OW       = 7
) (
    input logic                 clk,
    input logic                 rst,
    systolic_seq_ctrl_if.master bus
);
    localparam int IAW = $clog2(MAX_INST);
    localparam int IXW = IAW + 1;
    localparam int SW  = $clog2(N * N);
    localparam int NN  = N * N;
    localparam int LW  = CW + 1;
    localparam int PAD = 2 * (N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_STREAM,
        S_FLUSH,
        S_WRITE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [IXW-1:0]  idx_q, idx_d;
    logic [LW-1:0]   base_q, base_d;
    logic [OW-1:0]   obase_q, obase_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   t_q, t_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [IW-1:0]   inst_q, inst_d;
    logic            err_q, err_d;
    logic            pe_en_q, pe_en_d;
    logic            out_wr_q, out_wr_d;
    logic [OW-1:0]   out_addr_q, out_addr_d;
    logic [2*DW-1:0] out_data_q, out_data_d;

    logic [31:0] need_len;
    logic [31:0] need_end;
    logic        fits;
    logic        inst_zero;
    logic        last_t;
    logic        last_sel;
    logic        last_inst;

    // The overflow test runs in 32 bits so base+L == 2^CW is exactly representable.
    always_comb begin
        need_len  = 32'(bus.inst_data) + 32'(PAD);
        need_end  = 32'(base_q) + need_len;
        fits      = (need_end <= (32'd1 << CW));
        inst_zero = (bus.inst_data == '0);
        last_t    = (t_q == (len_q - LW'(1)));
        last_sel  = (sel_q == SW'(NN - 1));
        last_inst = ((idx_q + IXW'(1)) == IXW'(MAX_INST));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.ap_start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (inst_zero || !fits) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: if (last_t) state_d = S_FLUSH;
            S_FLUSH:  state_d = S_WRITE;
            S_WRITE:  if (last_sel) state_d = S_CLEAR;
            S_CLEAR:  state_d = last_inst ? S_DONE : S_FETCH;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d      = idx_q;
        base_d     = base_q;
        obase_d    = obase_q;
        len_d      = len_q;
        t_d        = t_q;
        sel_d      = sel_q;
        inst_d     = inst_q;
        err_d      = err_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        pe_en_d    = (state_q == S_STREAM);
        out_wr_d   = (state_q == S_WRITE);
        case (state_q)
            S_IDLE: begin
                if (bus.ap_start) begin
                    idx_d   = '0;
                    base_d  = '0;
                    obase_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_DECODE: begin
                if (!inst_zero) begin
                    inst_d = bus.inst_data;
                    if (fits) begin
                        len_d = LW'(need_len);
                        t_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                t_d = t_q + LW'(1);
            end
            S_WRITE: begin
                sel_d      = last_sel ? '0 : sel_q + SW'(1);
                out_addr_d = obase_q + OW'(sel_q);
                out_data_d = bus.res_data;
            end
            S_CLEAR: begin
                base_d  = base_q + len_q;
                obase_d = obase_q + OW'(NN);
                idx_d   = idx_q + IXW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            base_q     <= '0;
            obase_q    <= '0;
            len_q      <= '0;
            t_q        <= '0;
            sel_q      <= '0;
            inst_q     <= '0;
            err_q      <= 1'b0;
            pe_en_q    <= 1'b0;
            out_wr_q   <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            idx_q      <= idx_d;
            base_q     <= base_d;
            obase_q    <= obase_d;
            len_q      <= len_d;
            t_q        <= t_d;
            sel_q      <= sel_d;
            inst_q     <= inst_d;
            err_q      <= err_d;
            pe_en_q    <= pe_en_d;
            out_wr_q   <= out_wr_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        bus.ap_idle   = (state_q == S_IDLE);
        bus.ap_done   = (state_q == S_DONE);
        bus.mem_rd    = (state_q == S_STREAM);
        bus.acc_clr   = (state_q == S_CLEAR);
        bus.mem_col   = (state_q == S_STREAM) ? CW'(base_q + t_q) : '0;
        bus.inst_addr = idx_q[IAW-1:0];
        bus.cur_inst  = inst_q;
        bus.res_sel   = sel_q;
        bus.pe_en     = pe_en_q;
        bus.out_wr    = out_wr_q;
        bus.out_addr  = out_addr_q;
        bus.out_data  = out_data_q;
        bus.err       = err_q;
    end
endmodule
